// File: rtl/ic_tile_pf.sv
// rtl/ic_tile_pf.sv - direct-mapped fetch tile, 48-bit window from two adjacent 16-byte lines
// Optional next-line prefetch after each fill: IC_TILE_NEXTLINE_PREFETCH_EN.
module ic_tile_pf #(
    parameter int IDX_BITS = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  regInPc,
    input  logic         icFlush,
    output logic [47:0]  regOutPcVal,
    output logic [1:0]   regOutPcOK,
    input  logic [127:0] memPcData,
    input  logic [1:0]   memPcOK,
    output logic [31:0]  memPcAddr,
    output logic         memPcOE
);
    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = 28 - IDX_BITS;
    localparam logic [47:0] NOT_READY_VAL = 48'h0F3B_0F3B_0F3B;
    localparam logic [1:0] MEM_READY = 2'd0;
    localparam logic [1:0] MEM_OK    = 2'd1;
    localparam logic [1:0] MEM_FAULT = 2'd3;
    localparam logic [1:0] PC_NONE   = 2'd0;
    localparam logic [1:0] PC_VALID  = 2'd1;
    localparam logic [1:0] PC_FAULT  = 2'd2;

    typedef enum logic [1:0] {IDLE, FILL, FDONE, FAULT} fillState_t;
    fillState_t state, stateNext;

    logic [127:0]        lineData [LINES];
    logic [TAG_BITS-1:0] lineTag  [LINES];
    logic [LINES-1:0]    lineValid;

    logic [27:0]  missAd, faultAd, ld1, ld2, demandLine;
    logic         faultValid, fillKill;
    logic         hit1, hit2, faultHit, demandMiss, commit;
    logic [159:0] window;
    logic         unusedPcBit;

    function automatic logic lineHit(input logic [27:0] ld);
        return lineValid[ld[IDX_BITS-1:0]] && (lineTag[ld[IDX_BITS-1:0]] == ld[27:IDX_BITS]);
    endfunction

    // (PC+4)[31:4] only carries out of the line when PC[3:2] is 3
    assign ld1 = regInPc[31:4];
    assign ld2 = regInPc[31:4] + {27'd0, regInPc[3] & regInPc[2]};
    assign unusedPcBit = regInPc[0];

    assign hit1       = lineHit(ld1);
    assign hit2       = lineHit(ld2);
    assign faultHit   = faultValid && ((ld1 == faultAd) || (ld2 == faultAd));
    assign demandLine = hit1 ? ld2 : ld1;
    assign demandMiss = !(hit1 && hit2) && !(faultValid && (demandLine == faultAd));
    assign window     = {lineData[ld2[IDX_BITS-1:0]][31:0], lineData[ld1[IDX_BITS-1:0]]};

    // A flush seen at any point during the fill poisons its data
    assign commit = !reset && (state == FILL) && (memPcOK == MEM_OK) && !icFlush && !fillKill;

`ifdef IC_TILE_NEXTLINE_PREFETCH_EN
    logic [27:0] nextAd;
    logic        prefetchWanted;
    assign nextAd         = missAd + 28'd1;
    assign prefetchWanted = !lineHit(nextAd) && !(faultValid && (nextAd == faultAd));
`endif

    always_comb begin
        stateNext = state;
        memPcOE   = 1'b0;
        memPcAddr = 32'd0;
        case (state)
            IDLE: begin
                if (demandMiss) stateNext = FILL;
            end
            FILL: begin
                memPcOE   = 1'b1;
                memPcAddr = {missAd, 4'h0};
                if (memPcOK == MEM_OK) stateNext = FDONE;
                else if (memPcOK == MEM_FAULT) stateNext = FAULT;
            end
            FDONE: begin
                stateNext = IDLE;
`ifdef IC_TILE_NEXTLINE_PREFETCH_EN
                if (!demandMiss && prefetchWanted) stateNext = FILL;
`endif
            end
            FAULT: begin
                if (memPcOK == MEM_READY) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            lineValid  <= '0;
            faultValid <= 1'b0;
            faultAd    <= 28'd0;
            missAd     <= 28'd0;
            fillKill   <= 1'b0;
        end else begin
            state    <= stateNext;
            fillKill <= (state == FILL) && (fillKill || icFlush);
            if (state == IDLE && demandMiss) missAd <= demandLine;
`ifdef IC_TILE_NEXTLINE_PREFETCH_EN
            if (state == FDONE && stateNext == FILL) missAd <= nextAd;
`endif
            if (icFlush) lineValid <= '0;
            else if (commit) lineValid[missAd[IDX_BITS-1:0]] <= 1'b1;
            if (icFlush || commit) faultValid <= 1'b0;
            if (state == FILL && memPcOK == MEM_FAULT) begin
                faultValid <= 1'b1;
                faultAd    <= missAd;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (commit) begin
            lineData[missAd[IDX_BITS-1:0]] <= memPcData;
            lineTag[missAd[IDX_BITS-1:0]]  <= missAd[27:IDX_BITS];
        end
    end

    // Lookup reads pre-commit array contents, so a same-cycle fill shows up one cycle later
    always_ff @(posedge clock) begin
        if (reset) begin
            regOutPcVal <= NOT_READY_VAL;
            regOutPcOK  <= PC_NONE;
        end else if (hit1 && hit2) begin
            regOutPcVal <= window[{regInPc[3:1], 4'b0000} +: 48];
            regOutPcOK  <= PC_VALID;
        end else if (faultHit) begin
            regOutPcVal <= NOT_READY_VAL;
            regOutPcOK  <= PC_FAULT;
        end else begin
            regOutPcVal <= NOT_READY_VAL;
            regOutPcOK  <= PC_NONE;
        end
    end
endmodule

// File: tb/tb_ic_tile_pf.sv
// tb/tb_ic_tile_pf.sv - self-checking bench for ic_tile_pf with a behavioural fill memory
module tb_ic_tile_pf;
    localparam logic [47:0] NOT_READY = 48'h0F3B_0F3B_0F3B;

    logic         clock, reset, icFlush;
    logic [31:0]  regInPc;
    logic [47:0]  regOutPcVal;
    logic [1:0]   regOutPcOK;
    logic [127:0] memPcData;
    logic [1:0]   memPcOK;
    logic [31:0]  memPcAddr;
    logic         memPcOE;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nHolds = 0;
    int hcnt = 0;
    int oeCycles = 0;
    logic        faultEn = 1'b0;
    logic [27:0] faultLine = 28'd0;
    logic [31:0] fillLog[$];
    int          fillCyc[$];

    typedef struct {
        logic [31:0] pc;
        logic [47:0] val;
        logic [1:0]  ok;
    } vec_t;
    vec_t vecs[$];
    vec_t sbQ[$];

    ic_tile_pf #(.IDX_BITS(8)) dut (
        .clock(clock), .reset(reset), .regInPc(regInPc), .icFlush(icFlush),
        .regOutPcVal(regOutPcVal), .regOutPcOK(regOutPcOK),
        .memPcData(memPcData), .memPcOK(memPcOK), .memPcAddr(memPcAddr), .memPcOE(memPcOE)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] memDword(input logic [27:0] ln, input int k);
        logic [1:0] kk;
        kk = k[1:0];
        return {ln[15:0] ^ 16'h5A00, ln[11:0], 2'b00, kk};
    endfunction

    function automatic logic [127:0] memLine(input logic [27:0] ln);
        return {memDword(ln, 3), memDword(ln, 2), memDword(ln, 1), memDword(ln, 0)};
    endfunction

    function automatic logic [47:0] expWin(input logic [31:0] pc);
        logic [31:0]  p4;
        logic [159:0] w;
        int sh;
        p4 = pc + 32'd4;
        w  = {memDword(p4[31:4], 0), memLine(pc[31:4])};
        sh = 16 * int'(pc[3:1]);
        return w[sh +: 48];
    endfunction

    function automatic logic [31:0] fillAt(input int i);
        return (i < fillLog.size()) ? fillLog[i] : 32'hDEAD_DEAD;
    endfunction

    // Memory answers on the falling edge: HOLD nHolds times, then OK with line data
    always @(negedge clock) begin
        if (memPcOE) begin
            if (hcnt == 0) begin
                fillLog.push_back(memPcAddr);
                fillCyc.push_back(cyc);
            end
            oeCycles <= oeCycles + 1;
            hcnt     <= hcnt + 1;
            if (faultEn && memPcAddr[31:4] == faultLine) memPcOK <= 2'd3;
            else if (hcnt >= nHolds) begin
                memPcOK   <= 2'd1;
                memPcData <= memLine(memPcAddr[31:4]);
            end else memPcOK <= 2'd2;
        end else begin
            hcnt      <= 0;
            memPcOK   <= 2'd0;
            memPcData <= '0;
        end
    end

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic waitOk(input logic [1:0] exp, input int budget, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (regOutPcOK !== exp && n < budget);
        chk(name, {62'd0, regOutPcOK}, {62'd0, exp});
    endtask

    task automatic addVec(input logic [31:0] pc, input bit hit);
        vec_t v;
        v.pc  = pc;
        v.ok  = hit ? 2'd1 : 2'd0;
        v.val = hit ? expWin(pc) : NOT_READY;
        vecs.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t e;
        int oeBase, n;
        reset = 1'b1; icFlush = 1'b0; regInPc = 32'd0;
        repeat (3) tick();
        chk("reset val", regOutPcVal, NOT_READY);
        chk("reset ok", regOutPcOK, 0);
        chk("reset oe", memPcOE, 0);
        chk("reset addr", memPcAddr, 0);

        // Cold fill with three HOLDs
        regInPc = 32'h0000_1000; nHolds = 3; reset = 1'b0;
        waitOk(2'd1, 40, "cold ok");
        chk("cold fill addr", fillAt(0), 32'h0000_1000);
        chk("cold val", regOutPcVal, expWin(32'h0000_1000));
`ifndef IC_TILE_NEXTLINE_PREFETCH_EN
        chk("cold fill count", fillLog.size(), 1);
        chk("cold oe cycles", oeCycles, 4);
`endif

        // Straddle into an absent second line
        fillLog.delete(); nHolds = 1;
        regInPc = 32'h0000_100C;
        waitOk(2'd1, 40, "straddle ok");
        chk("straddle val", regOutPcVal, expWin(32'h0000_100C));
`ifndef IC_TILE_NEXTLINE_PREFETCH_EN
        chk("straddle fill count", fillLog.size(), 1);
        chk("straddle fill addr", fillAt(0), 32'h0000_1010);
`endif

        // Pipelined hit vectors over lines 0x100/0x101
        addVec(32'h0000_1000, 1); addVec(32'h0000_1002, 1); addVec(32'h0000_1004, 1);
        addVec(32'h0000_1006, 1); addVec(32'h0000_1009, 1); addVec(32'h0000_100A, 1);
        addVec(32'h0000_100E, 1); addVec(32'h0000_1010, 1); addVec(32'h0000_1016, 1);
        addVec(32'h0000_101A, 1); addVec(32'h0000_9040, 0); addVec(32'h0000_1004, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                chk($sformatf("vec pc=%h val", e.pc), regOutPcVal, e.val);
                chk($sformatf("vec pc=%h ok", e.pc), regOutPcOK, e.ok);
            end
            regInPc = vecs[i].pc;
            sbQ.push_back(vecs[i]);
        end
        tick();
        e = sbQ.pop_front();
        chk($sformatf("vec pc=%h val", e.pc), regOutPcVal, e.val);
        chk($sformatf("vec pc=%h ok", e.pc), regOutPcOK, e.ok);
        repeat (20) tick();

        // Faulting fill blocks refetch of that line until a fill elsewhere succeeds
        fillLog.delete(); nHolds = 0; faultEn = 1'b1; faultLine = 28'h000_0200;
        regInPc = 32'h0000_2000;
        waitOk(2'd2, 40, "fault ok");
        chk("fault fill count", fillLog.size(), 1);
        chk("fault fill addr", fillAt(0), 32'h0000_2000);
        oeBase = oeCycles;
        repeat (10) tick();
        chk("fault ok sticks", regOutPcOK, 2);
        chk("fault no oe", oeCycles, oeBase);
        regInPc = 32'h0000_1000;
        repeat (5) tick();
        chk("fault other line hit", regOutPcOK, 1);
        fillLog.delete(); faultEn = 1'b0;
        regInPc = 32'h0000_6040;
        waitOk(2'd1, 40, "fill elsewhere ok");
        chk("fill elsewhere addr", fillAt(0), 32'h0000_6040);
        regInPc = 32'h0000_2000;
        waitOk(2'd1, 40, "fault cleared refill ok");

        // Flush of a resident line, then flush coinciding with OK
        regInPc = 32'h0000_1000;
        waitOk(2'd1, 40, "pre flush ok");
        repeat (10) tick();
        fillLog.delete(); nHolds = 2;
        icFlush = 1'b1; tick(); icFlush = 1'b0; tick();
        chk("flush miss", regOutPcOK, 0);
        n = 0;
        while (!(memPcOE && memPcOK == 2'd1) && n < 40) begin
            tick();
            n++;
        end
        chk("flush refill reached ok", {31'd0, (n < 40)}, 1);
        chk("flush refill addr", fillAt(0), 32'h0000_1000);
        icFlush = 1'b1; tick(); icFlush = 1'b0; tick();
        chk("flush with ok discards", regOutPcOK, 0);
        waitOk(2'd1, 40, "refill after flush ok");

        // PC at the top of the address space wraps its second line to line 0
        fillLog.delete(); nHolds = 0;
        regInPc = 32'hFFFF_FFFC;
        waitOk(2'd1, 60, "wrap ok");
        chk("wrap fill0", fillAt(0), 32'hFFFF_FFF0);
        chk("wrap fill1", fillAt(1), 32'h0000_0000);
        chk("wrap val", regOutPcVal, expWin(32'hFFFF_FFFC));

        // Reset in the middle of a fill drops the request
        regInPc = 32'h0000_7000; nHolds = 20;
        n = 0;
        while (!memPcOE && n < 20) begin
            tick();
            n++;
        end
        chk("mid fill oe seen", memPcOE, 1);
        reset = 1'b1; tick();
        chk("mid fill reset oe", memPcOE, 0);
        chk("mid fill reset addr", memPcAddr, 0);
        chk("mid fill reset ok", regOutPcOK, 0);

        // Cold line with and without next-line prefetch
        fillLog.delete(); fillCyc.delete(); nHolds = 0;
        regInPc = 32'h0000_3000; reset = 1'b0;
        waitOk(2'd1, 40, "cold2 ok");
        repeat (10) tick();
        chk("cold2 fill0", fillAt(0), 32'h0000_3000);
`ifdef IC_TILE_NEXTLINE_PREFETCH_EN
        chk("prefetch fill count", fillLog.size(), 2);
        chk("prefetch fill1", fillAt(1), 32'h0000_3010);
        chk("prefetch gap", (fillCyc.size() > 1) ? fillCyc[1] - fillCyc[0] : 0, 2);
`else
        chk("no prefetch fill count", fillLog.size(), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
